// File: rtl/pcs_ll_fault_injector.sv
// Line-loopback fault injector for the 10GBASE-R SERDES path: corrupts selected blocks on the way out
// and checks the returned stream against a delayed clean copy, keeping saturating event counters.
module pcs_ll_fault_injector #(
    parameter int DATA_WIDTH   = 64,
    parameter int HDR_WIDTH    = 2,
    parameter int DELAY_DEPTH  = 6,
    parameter int COUNT_WIDTH  = 16,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [HDR_WIDTH-1:0]    in_hdr,
    input  logic                    in_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [HDR_WIDTH-1:0]    out_hdr,
    output logic                    out_valid,
    output logic                    inject_active,
    input  logic [1:0]              cfg_mode,
    input  logic                    cfg_start,
    input  logic [7:0]              cfg_burst_len,
    input  logic [PERIOD_WIDTH-1:0] cfg_period,
    input  logic [HDR_WIDTH-1:0]    cfg_hdr_value,
    input  logic                    cfg_hdr_en,
    input  logic [DATA_WIDTH-1:0]   cfg_data_xor,
    input  logic [DATA_WIDTH-1:0]   chk_data,
    input  logic [HDR_WIDTH-1:0]    chk_hdr,
    input  logic                    chk_valid,
    input  logic                    cnt_clear,
    output logic                    busy,
    output logic                    mismatch,
    output logic [COUNT_WIDTH-1:0]  inject_count,
    output logic [COUNT_WIDTH-1:0]  mismatch_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, GAP = 2'd2} state_t;
    localparam int CMP_W = (PERIOD_WIDTH > 8) ? PERIOD_WIDTH : 8;

    state_t                  r_state;
    logic [1:0]              r_mode_q;
    logic [7:0]              r_burst_cnt;
    logic [PERIOD_WIDTH-1:0] r_period_cnt;

    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [HDR_WIDTH-1:0]    r_out_hdr;
    logic                    r_out_valid;
    logic                    r_inject;
    logic                    r_mismatch;
    logic [COUNT_WIDTH-1:0]  r_inj_cnt;
    logic [COUNT_WIDTH-1:0]  r_mis_cnt;

    logic                    r_ref_vld  [DELAY_DEPTH];
    logic [HDR_WIDTH-1:0]    r_ref_hdr  [DELAY_DEPTH];
    logic [DATA_WIDTH-1:0]   r_ref_data [DELAY_DEPTH];

    logic                    w_corrupt;
    logic                    w_abort;
    logic [7:0]              w_burst_nxt;
    logic [PERIOD_WIDTH-1:0] w_period_nxt;
    logic                    w_burst_done;
    logic                    w_period_done;
    logic                    w_period_gt_len;
    logic                    w_mis;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

    assign w_corrupt       = in_valid && (cfg_mode != 2'd0) && (r_state == BURST);
    // Mode 0 always parks the FSM; any other mode change restarts it from IDLE.
    assign w_abort         = (cfg_mode == 2'd0) || ((r_state != IDLE) && (cfg_mode != r_mode_q));
    assign w_burst_nxt     = r_burst_cnt + 8'd1;
    assign w_period_nxt    = r_period_cnt + PERIOD_WIDTH'(1);
    assign w_burst_done    = (w_burst_nxt >= cfg_burst_len);
    assign w_period_done   = (w_period_nxt >= cfg_period);
    assign w_period_gt_len = (CMP_W'(cfg_period) > CMP_W'(cfg_burst_len));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mode_q     <= 2'd0;
            r_burst_cnt  <= 8'd0;
            r_period_cnt <= '0;
        end else begin
            r_mode_q <= cfg_mode;
            if (w_abort) begin
                r_state      <= IDLE;
                r_burst_cnt  <= 8'd0;
                r_period_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_burst_cnt  <= 8'd0;
                        r_period_cnt <= '0;
                        if (cfg_mode != 2'd1 || (cfg_start && cfg_burst_len != 8'd0))
                            r_state <= BURST;
                    end
                    BURST: if (in_valid && cfg_mode != 2'd3) begin
                        if (!w_burst_done) begin
                            r_burst_cnt  <= w_burst_nxt;
                            r_period_cnt <= w_period_nxt;
                        end else if (cfg_mode == 2'd1) begin
                            r_state      <= IDLE;
                            r_burst_cnt  <= 8'd0;
                            r_period_cnt <= '0;
                        end else if (w_period_gt_len) begin
                            r_state      <= GAP;
                            r_burst_cnt  <= 8'd0;
                            r_period_cnt <= w_period_nxt;
                        end else begin
                            // Period no longer than the burst: restart the burst back-to-back.
                            r_burst_cnt  <= 8'd0;
                            r_period_cnt <= '0;
                        end
                    end
                    GAP: if (in_valid) begin
                        if (w_period_done) begin
                            r_state      <= BURST;
                            r_burst_cnt  <= 8'd0;
                            r_period_cnt <= '0;
                        end else begin
                            r_period_cnt <= w_period_nxt;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_hdr   <= '0;
            r_out_valid <= 1'b0;
            r_inject    <= 1'b0;
            r_mismatch  <= 1'b0;
            r_inj_cnt   <= '0;
            r_mis_cnt   <= '0;
        end else begin
            r_out_data  <= w_corrupt ? (in_data ^ cfg_data_xor) : in_data;
            r_out_hdr   <= (w_corrupt && cfg_hdr_en) ? cfg_hdr_value : in_hdr;
            r_out_valid <= in_valid;
            r_inject    <= w_corrupt;
            r_mismatch  <= w_mis;
            if (cnt_clear) begin
                r_inj_cnt <= '0;
                r_mis_cnt <= '0;
            end else begin
                if (w_corrupt) r_inj_cnt <= sat_inc(r_inj_cnt);
                if (w_mis)     r_mis_cnt <= sat_inc(r_mis_cnt);
            end
        end
    end

    // Clean reference copy; only the valid bits need a known state after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DELAY_DEPTH; i++) r_ref_vld[i] <= 1'b0;
        end else begin
            r_ref_vld[0] <= in_valid;
            for (int i = 1; i < DELAY_DEPTH; i++) r_ref_vld[i] <= r_ref_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_ref_hdr[0]  <= in_hdr;
        r_ref_data[0] <= in_data;
        for (int i = 1; i < DELAY_DEPTH; i++) begin
            r_ref_hdr[i]  <= r_ref_hdr[i-1];
            r_ref_data[i] <= r_ref_data[i-1];
        end
    end

    assign w_mis = chk_valid && (!r_ref_vld[DELAY_DEPTH-1] ||
                                 (chk_data != r_ref_data[DELAY_DEPTH-1]) ||
                                 (chk_hdr  != r_ref_hdr[DELAY_DEPTH-1]));

    assign out_data       = r_out_data;
    assign out_hdr        = r_out_hdr;
    assign out_valid      = r_out_valid;
    assign inject_active  = r_inject;
    assign busy           = (r_state != IDLE);
    assign mismatch       = r_mismatch;
    assign inject_count   = r_inj_cnt;
    assign mismatch_count = r_mis_cnt;
endmodule

// File: tb/tb_pcs_ll_fault_injector.sv
// Directed bench for pcs_ll_fault_injector: vector table for the corrupting datapath plus
// hand-written sequences for burst/periodic timing, loopback checking, saturation and reset.
module tb_pcs_ll_fault_injector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_data = '0;
    logic [1:0]  in_hdr = '0;
    logic        in_valid = 1'b0;
    logic [1:0]  cfg_mode = '0;
    logic        cfg_start = 1'b0;
    logic [7:0]  cfg_burst_len = '0;
    logic [15:0] cfg_period = '0;
    logic [1:0]  cfg_hdr_value = '0;
    logic        cfg_hdr_en = 1'b0;
    logic [63:0] cfg_data_xor = '0;
    logic        cnt_clear = 1'b0;
    logic [63:0] chk_data, tb_chk_data = '0;
    logic [1:0]  chk_hdr, tb_chk_hdr = '0;
    logic        chk_valid, tb_chk_valid = 1'b0;
    logic        loop_en = 1'b0;

    logic [63:0] out_data;
    logic [1:0]  out_hdr;
    logic        out_valid, inject_active, busy, mismatch;
    logic [15:0] inject_count, mismatch_count;
    logic [63:0] s_out_data;
    logic [1:0]  s_out_hdr;
    logic        s_out_valid, s_inject_active, s_busy, s_mismatch;
    logic [3:0]  s_inject_count, s_mismatch_count;

    // Far-end model: returns out_* five cycles later, so it lines up with the 6-deep reference.
    logic [63:0] dly_data [5];
    logic [1:0]  dly_hdr  [5];
    logic        dly_vld  [5];
    always @(posedge clk) begin
        dly_data[0] <= out_data;
        dly_hdr[0]  <= out_hdr;
        dly_vld[0]  <= out_valid;
        for (int i = 1; i < 5; i++) begin
            dly_data[i] <= dly_data[i-1];
            dly_hdr[i]  <= dly_hdr[i-1];
            dly_vld[i]  <= dly_vld[i-1];
        end
    end
    assign chk_data  = loop_en ? dly_data[4] : tb_chk_data;
    assign chk_hdr   = loop_en ? dly_hdr[4]  : tb_chk_hdr;
    assign chk_valid = loop_en ? dly_vld[4]  : tb_chk_valid;

    always #5 clk = ~clk;

    pcs_ll_fault_injector u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_hdr(in_hdr), .in_valid(in_valid),
        .out_data(out_data), .out_hdr(out_hdr), .out_valid(out_valid), .inject_active(inject_active),
        .cfg_mode(cfg_mode), .cfg_start(cfg_start), .cfg_burst_len(cfg_burst_len),
        .cfg_period(cfg_period), .cfg_hdr_value(cfg_hdr_value), .cfg_hdr_en(cfg_hdr_en),
        .cfg_data_xor(cfg_data_xor), .chk_data(chk_data), .chk_hdr(chk_hdr), .chk_valid(chk_valid),
        .cnt_clear(cnt_clear), .busy(busy), .mismatch(mismatch),
        .inject_count(inject_count), .mismatch_count(mismatch_count)
    );

    pcs_ll_fault_injector #(.COUNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .in_data(in_data), .in_hdr(in_hdr), .in_valid(in_valid),
        .out_data(s_out_data), .out_hdr(s_out_hdr), .out_valid(s_out_valid), .inject_active(s_inject_active),
        .cfg_mode(cfg_mode), .cfg_start(cfg_start), .cfg_burst_len(cfg_burst_len),
        .cfg_period(cfg_period), .cfg_hdr_value(cfg_hdr_value), .cfg_hdr_en(cfg_hdr_en),
        .cfg_data_xor(cfg_data_xor), .chk_data(chk_data), .chk_hdr(chk_hdr), .chk_valid(chk_valid),
        .cnt_clear(cnt_clear), .busy(s_busy), .mismatch(s_mismatch),
        .inject_count(s_inject_count), .mismatch_count(s_mismatch_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [1:0]  mode;
        logic        valid;
        logic [63:0] data;
        logic [1:0]  hdr;
        logic [63:0] xmask;
        logic        hen;
        logic [1:0]  hv;
        logic [63:0] e_data;
        logic [1:0]  e_hdr;
        logic        e_valid;
        logic        e_inj;
    } vec_t;
    vec_t vecs [7];

    initial begin
        logic [63:0] d;
        logic        exp_inj;

        vecs[0] = '{2'd3, 1'b1, 64'h0123_4567_89AB_CDEF, 2'b01, 64'hFFFF_0000_FFFF_0000, 1'b0, 2'b00,
                    64'hFEDC_4567_7654_CDEF, 2'b01, 1'b1, 1'b1};
        vecs[1] = '{2'd3, 1'b1, 64'hAAAA_AAAA_5555_5555, 2'b10, 64'h1, 1'b1, 2'b11,
                    64'hAAAA_AAAA_5555_5554, 2'b11, 1'b1, 1'b1};
        vecs[2] = '{2'd3, 1'b0, 64'h1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'b00,
                    64'h1, 2'b01, 1'b0, 1'b0};
        vecs[3] = '{2'd0, 1'b1, 64'hDEAD_BEEF_0000_0001, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'b00,
                    64'hDEAD_BEEF_0000_0001, 2'b10, 1'b1, 1'b0};
        vecs[4] = '{2'd3, 1'b1, 64'h5, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'b00,
                    64'h5, 2'b01, 1'b1, 1'b0};
        vecs[5] = '{2'd3, 1'b1, 64'h5, 2'b01, 64'hF0, 1'b1, 2'b00,
                    64'hF5, 2'b00, 1'b1, 1'b1};
        vecs[6] = '{2'd3, 1'b1, 64'h0, 2'b10, 64'h0, 1'b0, 2'b11,
                    64'h0, 2'b10, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_data", out_data, 64'h0);
        check("rst_out_hdr", {62'h0, out_hdr}, 64'h0);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_inject", {63'h0, inject_active}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_mismatch", {63'h0, mismatch}, 64'h0);
        check("rst_inj_cnt", {48'h0, inject_count}, 64'h0);
        check("rst_mis_cnt", {48'h0, mismatch_count}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Returned block while the reference is still empty must flag
        tb_chk_valid = 1'b1;
        tick();
        check("chk_empty_ref_mis", {63'h0, mismatch}, 64'h1);
        check("chk_empty_ref_cnt", {48'h0, mismatch_count}, 64'h1);
        tb_chk_valid = 1'b0;
        tick();
        check("chk_invalid_no_mis", {63'h0, mismatch}, 64'h0);
        check("chk_invalid_cnt", {48'h0, mismatch_count}, 64'h1);

        // Datapath vector table, FSM parked in BURST by mode 3
        cfg_mode = 2'd3;
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            cfg_mode     = vecs[i].mode;
            in_valid     = vecs[i].valid;
            in_data      = vecs[i].data;
            in_hdr       = vecs[i].hdr;
            cfg_data_xor = vecs[i].xmask;
            cfg_hdr_en   = vecs[i].hen;
            cfg_hdr_value = vecs[i].hv;
            tick();
            check($sformatf("vec%0d_data", i), out_data, vecs[i].e_data);
            check($sformatf("vec%0d_hdr", i), {62'h0, out_hdr}, {62'h0, vecs[i].e_hdr});
            check($sformatf("vec%0d_valid", i), {63'h0, out_valid}, {63'h0, vecs[i].e_valid});
            check($sformatf("vec%0d_inj", i), {63'h0, inject_active}, {63'h0, vecs[i].e_inj});
        end

        // Mode 0 pass-through with loopback: nothing injected, nothing mismatched
        cfg_mode = 2'd0;
        cfg_data_xor = 64'hFFFF_FFFF_FFFF_FFFF;
        cfg_hdr_en = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = {$urandom, $urandom};
            in_hdr = 2'($urandom_range(3));
            cnt_clear = (i == 7);
            tick();
        end
        cnt_clear = 1'b0;
        loop_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            d = {$urandom, $urandom};
            in_data = d;
            in_hdr = 2'($urandom_range(3));
            tick();
            check("m0_passthru", out_data, d);
        end
        in_valid = 1'b0;
        repeat (7) tick();
        check("m0_inj_cnt", {48'h0, inject_count}, 64'h0);
        check("m0_mis_cnt", {48'h0, mismatch_count}, 64'h0);
        loop_en = 1'b0;

        // Mode 1 single burst of 3; a start pulse mid-burst must not re-arm
        cfg_mode = 2'd1;
        cfg_burst_len = 8'd3;
        cfg_hdr_en = 1'b1;
        cfg_hdr_value = 2'b00;
        cfg_data_xor = 64'h0;
        in_hdr = 2'b01;
        in_valid = 1'b1;
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) begin
                cfg_start = (k == 0 || k == 2);
                tick();
                exp_inj = (k >= 1 && k <= 3);
                check($sformatf("m1_r%0d_inj%0d", r, k), {63'h0, inject_active}, {63'h0, exp_inj});
                check($sformatf("m1_r%0d_hdr%0d", r, k), {62'h0, out_hdr}, exp_inj ? 64'h0 : 64'h1);
                check($sformatf("m1_r%0d_busy%0d", r, k), {63'h0, busy}, {63'h0, (k <= 2)});
            end
            check($sformatf("m1_r%0d_inj_cnt", r), {48'h0, inject_count}, 64'(3 * (r + 1)));
        end
        cfg_burst_len = 8'd0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("m1_len0_ignored", {63'h0, busy}, 64'h0);
        tick();
        check("m1_len0_no_inj", {63'h0, inject_active}, 64'h0);

        // Mode 2 periodic: burst 2 every 10 valid blocks, valid every other cycle
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        cfg_mode = 2'd2;
        cfg_burst_len = 8'd2;
        cfg_period = 16'd10;
        for (int j = 0; j < 100; j++) begin
            in_valid = (j % 2 == 1);
            in_data = 64'(j);
            tick();
            exp_inj = (j % 2 == 1) && ((((j - 1) / 2) % 10) < 2);
            check($sformatf("m2_inj_cyc%0d", j), {63'h0, inject_active}, {63'h0, exp_inj});
        end
        check("m2_inj_cnt", {48'h0, inject_count}, 64'd10);

        // Loopback with a 4-block burst, bit 0 flipped
        cfg_mode = 2'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = {$urandom, $urandom};
            cnt_clear = (i == 7);
            tick();
        end
        cnt_clear = 1'b0;
        cfg_mode = 2'd1;
        cfg_burst_len = 8'd4;
        cfg_data_xor = 64'h1;
        cfg_hdr_en = 1'b0;
        loop_en = 1'b1;
        for (int k = 0; k < 14; k++) begin
            cfg_start = (k == 0);
            in_data = {$urandom, $urandom};
            tick();
            check($sformatf("lb_mis_cyc%0d", k), {63'h0, mismatch}, {63'h0, (k >= 7 && k <= 10)});
        end
        check("lb_mis_cnt", {48'h0, mismatch_count}, 64'd4);
        check("lb_inj_cnt", {48'h0, inject_count}, 64'd4);
        loop_en = 1'b0;

        // Saturation on the 4-bit instance, then clear racing an increment
        cfg_mode = 2'd3;
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        repeat (20) tick();
        check("sat_cnt4_hold", {60'h0, s_inject_count}, 64'd15);
        check("sat_cnt16_count", {48'h0, inject_count}, 64'd20);
        cnt_clear = 1'b1;
        tick();
        check("sat_clear_wins", {60'h0, s_inject_count}, 64'd0);
        check("sat_clear_wins16", {48'h0, inject_count}, 64'd0);
        cnt_clear = 1'b0;
        tick();
        check("sat_resume", {60'h0, s_inject_count}, 64'd1);

        // Asynchronous reset in the middle of a mode-2 burst
        cfg_mode = 2'd2;
        cfg_burst_len = 8'd4;
        cfg_period = 16'd8;
        cfg_hdr_en = 1'b1;
        cfg_hdr_value = 2'b11;
        in_hdr = 2'b01;
        repeat (4) tick();
        check("rstmid_pre_inj", {63'h0, inject_active}, 64'h1);
        rst = 1'b1;
        #1;
        check("rstmid_valid", {63'h0, out_valid}, 64'h0);
        check("rstmid_inj", {63'h0, inject_active}, 64'h0);
        check("rstmid_data", out_data, 64'h0);
        check("rstmid_busy", {63'h0, busy}, 64'h0);
        check("rstmid_cnt", {48'h0, inject_count}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rstrel_idle_inj", {63'h0, inject_active}, 64'h0);
        check("rstrel_busy", {63'h0, busy}, 64'h1);
        tick();
        check("rstrel_first_inj", {63'h0, inject_active}, 64'h1);
        check("rstrel_first_hdr", {62'h0, out_hdr}, 64'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
